// File: rtl/frame_readout_ctrl.sv
// Streams a ready frame from the ping-pong buffer read port into the SPI byte engine, one byte prefetched ahead.
// Define FRAME_HEADER_EN to prefix each readout with the header bytes A5 5A <frame_count> 00.
module frame_readout_ctrl #(
    parameter int FRAME_BYTES = 9600,
    parameter int RD_LAT      = 1,
    parameter int ADDR_W      = 17
) (
    input  logic              sys_clk,
    input  logic              nreset,
    input  logic              buffer_ready,
    output logic              frame_read_complete,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    input  logic              start,
    input  logic              abort,
    input  logic              byte_req,
    output logic [7:0]        tx_byte,
    output logic              tx_valid,
    output logic              busy,
    output logic              underrun,
    output logic [7:0]        frame_count
);

    typedef enum logic [2:0] {IDLE, WAIT_RDY, HDR, FETCH, HOLD, DONE} state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_BYTES - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [1:0]        LAT_LAST  = 2'(RD_LAT - 1);
`ifdef FRAME_HEADER_EN
    localparam state_t FIRST = HDR;
`else
    localparam state_t FIRST = FETCH;
`endif

    state_t     state, state_next;
    logic [1:0] wait_cnt;
    logic       start_ok;
    logic       abort_ok;

    // A same-cycle abort cancels a start issued from IDLE.
    assign start_ok = (state == IDLE) && start && !abort;
    assign abort_ok = (state != IDLE) && abort;

`ifdef FRAME_HEADER_EN
    logic [1:0] hdr_idx;

    function automatic logic [7:0] hdr_byte(input logic [1:0] idx, input logic [7:0] cnt);
        case (idx)
            2'd0:    return 8'hA5;
            2'd1:    return 8'h5A;
            2'd2:    return cnt;
            default: return 8'h00;
        endcase
    endfunction
`endif

    always_ff @(posedge sys_clk or negedge nreset) begin
        if (!nreset) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next          = state;
        busy                = (state != IDLE);
        frame_read_complete = (state == DONE);
        case (state)
            IDLE:     if (start_ok) state_next = buffer_ready ? FIRST : WAIT_RDY;
            WAIT_RDY: if (buffer_ready) state_next = FIRST;
`ifdef FRAME_HEADER_EN
            HDR:      if (byte_req && hdr_idx == 2'd3) state_next = FETCH;
`endif
            FETCH:    if (wait_cnt == LAT_LAST) state_next = HOLD;
            HOLD:     if (byte_req) state_next = (rd_addr == LAST_ADDR) ? DONE : FETCH;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
        if (abort_ok) state_next = IDLE;
    end

    always_ff @(posedge sys_clk or negedge nreset) begin
        if (!nreset) begin
            rd_addr     <= '0;
            tx_byte     <= 8'h00;
            tx_valid    <= 1'b0;
            underrun    <= 1'b0;
            frame_count <= 8'h00;
            wait_cnt    <= 2'd0;
`ifdef FRAME_HEADER_EN
            hdr_idx     <= 2'd0;
`endif
        end else begin
            // FETCH is always entered with the counter at zero, so it measures RD_LAT from the address edge.
            wait_cnt <= (state == FETCH) ? wait_cnt + 2'd1 : 2'd0;

            if (state == DONE) frame_count <= frame_count + 8'd1;

            if (start_ok)
                underrun <= 1'b0;
            else if (state != IDLE && byte_req && !tx_valid && !abort)
                underrun <= 1'b1;

            if (start_ok)
                rd_addr <= '0;
            else if (state == HOLD && byte_req && !abort && rd_addr != LAST_ADDR)
                rd_addr <= rd_addr + ADDR_ONE;

            if (abort_ok) begin
                tx_valid <= 1'b0;
            end else begin
                if (state == FETCH && wait_cnt == LAT_LAST) begin
                    tx_byte  <= rd_data;
                    tx_valid <= 1'b1;
                end
                if (state == HOLD && byte_req) tx_valid <= 1'b0;
`ifdef FRAME_HEADER_EN
                if (state != HDR && state_next == HDR) begin
                    hdr_idx  <= 2'd0;
                    tx_byte  <= hdr_byte(2'd0, frame_count);
                    tx_valid <= 1'b1;
                end
                if (state == HDR && byte_req) begin
                    if (hdr_idx == 2'd3) begin
                        tx_valid <= 1'b0;
                    end else begin
                        hdr_idx <= hdr_idx + 2'd1;
                        tx_byte <= hdr_byte(hdr_idx + 2'd1, frame_count);
                    end
                end
`endif
            end
        end
    end

endmodule

// File: tb/tb_frame_readout_ctrl.sv
// Directed bench for frame_readout_ctrl (default build, no header) with a transaction-level reference model.
module tb_frame_readout_ctrl;

    localparam int FRAME_BYTES = 9600;
    localparam int RD_LAT      = 1;
    localparam int ADDR_W      = 17;

    logic              sys_clk = 1'b0;
    logic              nreset;
    logic              buffer_ready;
    logic              frame_read_complete;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              start;
    logic              abort;
    logic              byte_req;
    logic [7:0]        tx_byte;
    logic              tx_valid;
    logic              busy;
    logic              underrun;
    logic [7:0]        frame_count;

    int tests  = 0;
    int failed = 0;
    int pulses = 0;
    logic [7:0] last_byte;

    frame_readout_ctrl #(
        .FRAME_BYTES(FRAME_BYTES),
        .RD_LAT     (RD_LAT),
        .ADDR_W     (ADDR_W)
    ) dut (
        .sys_clk            (sys_clk),
        .nreset             (nreset),
        .buffer_ready       (buffer_ready),
        .frame_read_complete(frame_read_complete),
        .rd_addr            (rd_addr),
        .rd_data            (rd_data),
        .start              (start),
        .abort              (abort),
        .byte_req           (byte_req),
        .tx_byte            (tx_byte),
        .tx_valid           (tx_valid),
        .busy               (busy),
        .underrun           (underrun),
        .frame_count        (frame_count)
    );

    always #5 sys_clk = ~sys_clk;

    // Frame buffer contents: each byte equals the low 8 bits of its address (RD_LAT = 1).
    assign rd_data = rd_addr[7:0];

    // Reference model: tracks the stream position and when the next byte becomes available.
    typedef struct packed {
        logic        busy;
        logic        waiting;
        logic        valid;
        logic        done;
        logic        und;
        logic [31:0] idx;
        logic [31:0] cd;
        logic [7:0]  fc;
        logic [7:0]  byt;
    } mstate_t;

    mstate_t m;

    function automatic mstate_t step(mstate_t s, logic st, logic ab, logic br, logic rdy);
        mstate_t n;
        n = s;
        if (s.done) begin
            n.done = 1'b0;
            n.busy = 1'b0;
            n.fc   = s.fc + 8'd1;
            if (br && !ab) n.und = 1'b1;
        end else if (!s.busy) begin
            if (st && !ab) begin
                n.busy  = 1'b1;
                n.und   = 1'b0;
                n.idx   = 0;
                n.valid = 1'b0;
                if (rdy) begin
                    n.waiting = 1'b0;
                    n.cd      = RD_LAT;
                end else begin
                    n.waiting = 1'b1;
                end
            end
        end else if (ab) begin
            n.busy    = 1'b0;
            n.valid   = 1'b0;
            n.waiting = 1'b0;
            n.cd      = 0;
        end else begin
            if (br && !s.valid) n.und = 1'b1;
            if (s.waiting) begin
                if (rdy) begin
                    n.waiting = 1'b0;
                    n.cd      = RD_LAT;
                end
            end else if (s.valid) begin
                if (br) begin
                    n.valid = 1'b0;
                    if (s.idx == FRAME_BYTES - 1) begin
                        n.done = 1'b1;
                    end else begin
                        n.idx = s.idx + 1;
                        n.cd  = RD_LAT;
                    end
                end
            end else if (s.cd > 0) begin
                n.cd = s.cd - 1;
                if (s.cd == 1) begin
                    n.valid = 1'b1;
                    n.byt   = s.idx[7:0];
                end
            end
        end
        return n;
    endfunction

    always @(posedge sys_clk or negedge nreset) begin
        if (!nreset) m <= '0;
        else         m <= step(m, start, abort, byte_req, buffer_ready);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge sys_clk) begin
        if (nreset) begin
            chk("m_tx_valid", 32'(tx_valid), 32'(m.valid));
            chk("m_busy", 32'(busy), 32'(m.busy | m.done));
            chk("m_underrun", 32'(underrun), 32'(m.und));
            chk("m_frame_count", 32'(frame_count), 32'(m.fc));
            chk("m_complete", 32'(frame_read_complete), 32'(m.done));
            chk("m_rd_addr", 32'(rd_addr), m.idx);
            if (m.valid) chk("m_tx_byte", 32'(tx_byte), 32'(m.byt));
            if (frame_read_complete) pulses++;
        end
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
        start    = 1'b0;
        abort    = 1'b0;
        byte_req = 1'b0;
    endtask

    task automatic wait_valid();
        int n;
        n = 0;
        while (!tx_valid && n < 10) begin
            tick();
            n++;
        end
        if (!tx_valid) chk("valid_timeout", 32'(tx_valid), 32'd1);
    endtask

    task automatic consume(input int count);
        for (int i = 0; i < count; i++) begin
            wait_valid();
            last_byte = tx_byte;
            byte_req  = 1'b1;
            tick();
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nreset       = 1'b0;
        buffer_ready = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        byte_req     = 1'b0;
        last_byte    = 8'h00;
        repeat (3) @(posedge sys_clk);
        #1;
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_tx_byte", 32'(tx_byte), 32'h00);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_count", 32'(frame_count), 32'd0);
        chk("rst_underrun", 32'(underrun), 32'd0);
        nreset = 1'b1;
        tick();

        // Full frame with the buffer already ready.
        buffer_ready = 1'b1;
        start = 1'b1;
        tick();
        chk("first_not_yet_valid", 32'(tx_valid), 32'd0);
        tick();
        chk("first_valid", 32'(tx_valid), 32'd1);
        chk("first_byte", 32'(tx_byte), 32'h00);
        consume(FRAME_BYTES);
        tick();
        chk("full_last_byte", 32'(last_byte), 32'h7F);
        chk("full_pulses", 32'(pulses), 32'd1);
        chk("full_frame_count", 32'(frame_count), 32'd1);
        chk("full_busy_after", 32'(busy), 32'd0);
        chk("full_rd_addr_held", 32'(rd_addr), 32'd9599);

        // Start before the buffer is ready.
        buffer_ready = 1'b0;
        start = 1'b1;
        tick();
        repeat (50) tick();
        chk("wait_busy", 32'(busy), 32'd1);
        chk("wait_tx_valid", 32'(tx_valid), 32'd0);
        chk("wait_rd_addr", 32'(rd_addr), 32'd0);
        buffer_ready = 1'b1;
        tick();
        chk("rdy_plus1_valid", 32'(tx_valid), 32'd0);
        tick();
        chk("rdy_plus2_valid", 32'(tx_valid), 32'd1);
        chk("rdy_plus2_byte", 32'(tx_byte), 32'h00);

        // Underrun: request again right after a consume.
        byte_req = 1'b1;
        tick();
        chk("ur_rd_addr_1", 32'(rd_addr), 32'd1);
        byte_req = 1'b1;
        tick();
        chk("ur_set", 32'(underrun), 32'd1);
        chk("ur_rd_addr_still_1", 32'(rd_addr), 32'd1);
        chk("ur_byte_not_skipped", 32'(tx_byte), 32'h01);

        // Abort, then restart clears underrun.
        abort = 1'b1;
        tick();
        chk("abort_idle", 32'(busy), 32'd0);
        chk("abort_tx_valid", 32'(tx_valid), 32'd0);
        start = 1'b1;
        tick();
        chk("restart_underrun_clear", 32'(underrun), 32'd0);
        chk("restart_rd_addr", 32'(rd_addr), 32'd0);

        // Abort after 100 bytes, colliding with a byte_req.
        consume(100);
        wait_valid();
        abort    = 1'b1;
        byte_req = 1'b1;
        tick();
        chk("abort100_busy", 32'(busy), 32'd0);
        chk("abort100_rd_addr", 32'(rd_addr), 32'd100);
        chk("abort100_frame_count", 32'(frame_count), 32'd1);
        chk("abort100_pulses", 32'(pulses), 32'd1);

        // Start and abort together in IDLE stays idle.
        start = 1'b1;
        abort = 1'b1;
        tick();
        chk("start_abort_idle", 32'(busy), 32'd0);

        start = 1'b1;
        tick();
        tick();
        chk("reread_first_byte", 32'(tx_byte), 32'h00);
        chk("reread_valid", 32'(tx_valid), 32'd1);

        // Asynchronous reset mid-frame.
        consume(500);
        chk("pre_reset_rd_addr", 32'(rd_addr), 32'd500);
        #2;
        nreset = 1'b0;
        #1;
        chk("arst_rd_addr", 32'(rd_addr), 32'd0);
        chk("arst_tx_valid", 32'(tx_valid), 32'd0);
        chk("arst_tx_byte", 32'(tx_byte), 32'h00);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_frame_count", 32'(frame_count), 32'd0);
        chk("arst_complete", 32'(frame_read_complete), 32'd0);
        @(posedge sys_clk);
        #1;
        nreset = 1'b1;
        repeat (3) tick();
        chk("arst_no_pulse", 32'(pulses), 32'd1);
        chk("arst_still_idle", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/frame_readout_ctrl.md
Name: frame_readout_ctrl

Overview:
- sys_clk-domain sequencer between the ping-pong frame buffer's read port and the SPI slave byte engine.
- On an MCU start request it waits for a ready frame, then streams FRAME_BYTES packed pixel bytes by driving the buffer byte address.
- It prefetches each byte so the SPI engine always has data, and pulses frame_read_complete when the last byte is consumed, releasing the buffer for the next ping-pong swap.

Parameters:
- FRAME_BYTES, 9600: bytes per frame (320x240 at 1 bpp / 8).
- RD_LAT, 1: cycles from rd_addr update to valid rd_data (legal values 1..3).
- ADDR_W, 17: width of rd_addr.

Ports:
- sys_clk  input  1  system clock, 48 MHz.
- nreset  input  1  asynchronous active-low reset.
- buffer_ready  input  1  level; a completed frame is readable.
- frame_read_complete  output  1  1-cycle pulse; frame fully consumed.
- rd_addr  output  ADDR_W  byte address into the frame buffer, 0..FRAME_BYTES-1.
- rd_data  input  8  byte returned for rd_addr.
- start  input  1  1-cycle pulse (synchronised SPI CS fall); begin a frame readout.
- abort  input  1  1-cycle pulse (synchronised SPI CS rise); cancel the readout.
- byte_req  input  1  1-cycle pulse; SPI engine consumes tx_byte.
- tx_byte  output  8  next byte to shift out.
- tx_valid  output  1  tx_byte holds an unconsumed byte.
- busy  output  1  high in any state other than IDLE.
- underrun  output  1  sticky; byte_req arrived while tx_valid=0. Cleared by start.
- frame_count  output  8  completed readouts, wraps 255 to 0.

Behaviour:
- Reset values: rd_addr=0, tx_byte=0x00, tx_valid=0, frame_read_complete=0, busy=0, underrun=0, frame_count=0, state=IDLE.
- States: IDLE, WAIT_RDY, FETCH, HOLD, DONE.
- IDLE:
  - On start: clear underrun.
  - If buffer_ready=1, go to FETCH with rd_addr=0.
  - Otherwise go to WAIT_RDY.
  - byte_req in IDLE is ignored and does not set underrun.
- WAIT_RDY: stay until buffer_ready=1, then go to FETCH with rd_addr=0.
- FETCH:
  - Wait counter counts RD_LAT cycles after the edge that loaded rd_addr.
  - On the edge where the counter expires: tx_byte<=rd_data, tx_valid<=1, go to HOLD.
  - rd_addr is held stable throughout FETCH.
- HOLD, on byte_req:
  - tx_valid<=0.
  - If rd_addr==FRAME_BYTES-1, go to DONE.
  - Otherwise rd_addr<=rd_addr+1 and go to FETCH.
- Prefetch means the start-to-first-tx_valid latency is 1+RD_LAT cycles; byte_req-to-next-tx_valid is also 1+RD_LAT cycles.
- byte_req while tx_valid=0 (in FETCH, WAIT_RDY or DONE) sets underrun and is otherwise ignored. No address advance, no byte skipped.
- DONE:
  - Assert frame_read_complete for exactly 1 cycle.
  - frame_count<=frame_count+1.
  - Go to IDLE; rd_addr stays at its last value.
- abort in any non-IDLE state:
  - Next state IDLE, tx_valid=0.
  - No frame_read_complete pulse, frame_count unchanged; the buffer stays held for a re-read.
- abort and byte_req in the same cycle: abort wins.
- abort in the same cycle as the DONE pulse: the pulse is still emitted.
- start while busy: ignored.
- start and abort in the same cycle in IDLE: abort wins, stay in IDLE.
- buffer_ready falling mid-stream is ignored; readout continues to the end.
- rd_addr arithmetic:
  - Unsigned ADDR_W.
  - Never exceeds FRAME_BYTES-1; no wrap within a frame.
  - Reset to 0 on each start.
- nreset assertion mid-frame forces all reset values immediately (asynchronous) and never emits frame_read_complete.

Optional Feature:
- Macro: FRAME_HEADER_EN.
- Defined:
  - Each readout is prefixed with 4 header bytes 0xA5, 0x5A, frame_count, 0x00, served from a HDR state placed ahead of the first FETCH.
  - The first header byte is presented at tx_valid 1 cycle after start, or after buffer_ready rises if the controller had to wait in WAIT_RDY.
  - Header bytes do not drive or advance rd_addr.
  - Stream length is FRAME_BYTES+4.
  - underrun and abort rules apply identically during the header.
- Undefined: no header; the stream begins with pixel byte 0.

Test Plan:
- buffer_ready=1, start, RD_LAT=1, model returns addr[7:0]; issue 9600 byte_req spaced 16 cycles apart -> bytes 0x00,0x01,...,0x7F (=9599&0xFF) in order; one frame_read_complete pulse after the 9600th req; frame_count=1; busy low afterwards.
- buffer_ready=0, start, raise buffer_ready 50 cycles later -> busy=1 and tx_valid=0 for those 50 cycles; rd_addr=0; tx_valid rises 2 cycles after buffer_ready.
- byte_req on the cycle right after a consume (tx_valid=0) -> underrun=1; rd_addr advances by only 1; no byte skipped. Next start -> underrun=0.
- Abort after 100 bytes -> idle within 1 cycle, no complete pulse, frame_count unchanged. Then start -> rd_addr restarts at 0; first byte is 0x00.
- nreset low during FETCH at rd_addr=500 -> all outputs at reset values immediately; no complete pulse.
- FRAME_HEADER_EN defined, frame_count=3 -> first 4 bytes A5,5A,03,00, then pixel bytes; complete pulse after the 9604th req.
